// File: rtl/debounce_scan_arbiter.sv
// ---------------------------------------------------------------------------
// debounce_scan_arbiter
//
// Shared-engine debouncer for N_CH switch inputs. One slow sample tick starts
// a sequential scan that updates one channel per clock. A channel's debounced
// level flips after STABLE_CNT consecutive scans that disagree with it. Every
// flip that counts as an event sets a per-channel pending bit. A round-robin
// arbiter presents the pending events one at a time on a valid/ready port.
//
// Optional build macro: DEBOUNCE_EVT_RELEASE_EN
//   defined   : presses and releases both raise events (o_evt_rise = new level)
//   undefined : only presses raise events; releases just update o_level,
//               are never held back by a pending press, and o_evt_rise is 1
//               whenever o_evt_valid is 1
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous, active-high reset
//   d_input      raw, asynchronous switch inputs (N_CH bits)
//   o_level      debounced levels (N_CH bits)
//   o_evt_valid  an event is presented
//   o_evt_ch     channel index of the presented event
//   o_evt_rise   1 = press (0->1), 0 = release (1->0)
//   i_evt_ready  consumer takes the event when high together with o_evt_valid
// ---------------------------------------------------------------------------
module debounce_scan_arbiter #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 250000,
    parameter int STABLE_CNT = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_CH-1:0]         d_input,
    output logic [N_CH-1:0]         o_level,
    output logic                    o_evt_valid,
    output logic [$clog2(N_CH)-1:0] o_evt_ch,
    output logic                    o_evt_rise,
    input  logic                    i_evt_ready
);

    localparam int CH_W   = $clog2(N_CH);
    localparam int CW1    = CH_W + 1;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int CNT_W  = 4;

    generate
        if (TICK_DIV <= N_CH + 1) begin : g_bad_tick_div
            $error("debounce_scan_arbiter: TICK_DIV must be greater than N_CH+1");
        end
        if (N_CH < 2 || N_CH > 16) begin : g_bad_n_ch
            $error("debounce_scan_arbiter: N_CH must be in 2..16");
        end
        if (STABLE_CNT < 1 || STABLE_CNT > 15) begin : g_bad_stable_cnt
            $error("debounce_scan_arbiter: STABLE_CNT must be in 1..15");
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    // Two-flop synchronizer
    logic [N_CH-1:0]   sync1_q, sync1_d;
    logic [N_CH-1:0]   sync2_q, sync2_d;

    // Sample tick
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    // Scan sequencer
    state_t            state_q, state_d;
    logic [CH_W-1:0]   idx_q, idx_d;
    logic              scan_en;

    // Per-channel debounce state
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [CNT_W-1:0]  cnt_d [N_CH];
    logic [N_CH-1:0]   level_q, level_d;
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [N_CH-1:0]   dir_q, dir_d;
    logic [N_CH-1:0]   pend_set;
    logic [N_CH-1:0]   pend_clr;
    logic [N_CH-1:0]   evt_flip;

    // Arbiter / event port
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
    logic              evt_rise_q, evt_rise_d;
    logic              sel_found;
    logic [CH_W-1:0]   sel_ch;
    logic [CW1-1:0]    cand;
    logic [CW1-1:0]    rr_next;

    // Which flips count as events (and can therefore be held off by pending)
`ifdef DEBOUNCE_EVT_RELEASE_EN
    assign evt_flip = {N_CH{1'b1}};
`else
    assign evt_flip = sync2_q;
`endif

    // ---------------- synchronizer and tick ----------------
    always_comb begin
        sync1_d    = d_input;
        sync2_d    = sync1_q;
        tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end

    // ---------------- scan FSM ----------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        scan_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                scan_en = 1'b1;
                if (idx_q == CH_W'(N_CH - 1)) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CH_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // ---------------- per-channel debounce update ----------------
    always_comb begin
        level_d  = level_q;
        dir_d    = dir_q;
        pend_set = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (scan_en && idx_q == CH_W'(ch)) begin
                if (sync2_q[ch] == level_q[ch]) begin
                    cnt_d[ch] = '0;
                end else if (cnt_q[ch] < CNT_W'(STABLE_CNT - 1)) begin
                    cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                end else if (pend_q[ch] && evt_flip[ch]) begin
                    // Previous event not yet taken: keep the count armed so the
                    // flip happens on the first scan after acceptance.
                    cnt_d[ch] = CNT_W'(STABLE_CNT - 1);
                end else begin
                    level_d[ch] = sync2_q[ch];
                    cnt_d[ch]   = '0;
                    if (evt_flip[ch]) begin
                        pend_set[ch] = 1'b1;
                        dir_d[ch]    = sync2_q[ch];
                    end
                end
            end
        end
    end

    // ---------------- round-robin arbiter and event port ----------------
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        cand      = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = {1'b0, rr_ptr_q} + CW1'(k);
            if (cand >= CW1'(N_CH)) begin
                cand = cand - CW1'(N_CH);
            end
            if (!sel_found && pend_q[cand[CH_W-1:0]]) begin
                sel_found = 1'b1;
                sel_ch    = cand[CH_W-1:0];
            end
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_rise_d  = evt_rise_q;
        rr_ptr_d    = rr_ptr_q;
        pend_clr    = '0;
        rr_next     = {1'b0, evt_ch_q} + CW1'(1);
        if (rr_next == CW1'(N_CH)) begin
            rr_next = '0;
        end
        if (evt_valid_q) begin
            if (i_evt_ready) begin
                // Accept: drop valid for one cycle so the next pick sees
                // the updated pending vector and pointer.
                evt_valid_d        = 1'b0;
                pend_clr[evt_ch_q] = 1'b1;
                rr_ptr_d           = rr_next[CH_W-1:0];
            end
        end else if (sel_found) begin
            evt_valid_d = 1'b1;
            evt_ch_d    = sel_ch;
            // Without release events dir is only ever written with 1.
            evt_rise_d  = dir_q[sel_ch];
        end
        // Scan reads the pre-accept pending bit, so a same-cycle clear wins.
        pend_d = (pend_q | pend_set) & ~pend_clr;
    end

    // ---------------- state registers ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            tick_cnt_q  <= '0;
            state_q     <= S_IDLE;
            idx_q       <= '0;
            level_q     <= '0;
            pend_q      <= '0;
            dir_q       <= '0;
            rr_ptr_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_rise_q  <= 1'b0;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            tick_cnt_q  <= tick_cnt_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            level_q     <= level_d;
            pend_q      <= pend_d;
            dir_q       <= dir_d;
            rr_ptr_q    <= rr_ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_rise_q  <= evt_rise_d;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    assign o_level     = level_q;
    assign o_evt_valid = evt_valid_q;
    assign o_evt_ch    = evt_ch_q;
    assign o_evt_rise  = evt_rise_q;

endmodule

// File: tb/tb_debounce_scan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_debounce_scan_arbiter
//
// Bench for debounce_scan_arbiter with N_CH=4, TICK_DIV=8, STABLE_CNT=3.
// A behavioural reference model derives the scan position from the cycle
// count since reset and picks events by round-robin distance; every clock
// the DUT outputs are compared against it. A table of settle steps and a
// few hand-written sequences cover the multi-cycle corner cases, followed
// by a randomized run.
// ---------------------------------------------------------------------------
module tb_debounce_scan_arbiter;

    localparam int N  = 4;
    localparam int T  = 8;
    localparam int SC = 3;
`ifdef DEBOUNCE_EVT_RELEASE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         ready = 1'b0;
    logic [N-1:0] d_in  = '0;
    logic [N-1:0] o_level;
    logic         o_valid;
    logic [1:0]   o_ch;
    logic         o_rise;

    always #5 clk = ~clk;

    debounce_scan_arbiter #(
        .N_CH       (N),
        .TICK_DIV   (T),
        .STABLE_CNT (SC)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .d_input     (d_in),
        .o_level     (o_level),
        .o_evt_valid (o_valid),
        .o_evt_ch    (o_ch),
        .o_evt_rise  (o_rise),
        .i_evt_ready (ready)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int ch;
        bit rise;
    } ev_t;
    ev_t ev_log[$];

    typedef struct {
        logic [N-1:0] d;
        logic         rdy;
        int           hold;
        logic [N-1:0] lvl;
        int           n_rise;
        int           n_fall;
    } vec_t;
    vec_t vecs[6];

    // ---------------- reference model ----------------
    int m_cyc;
    bit m_s1 [N];
    bit m_s2 [N];
    bit m_lvl [N];
    bit m_pend [N];
    bit m_dir [N];
    int m_cnt [N];
    bit m_valid;
    bit m_rise;
    int m_ch;
    int m_rr;

    task automatic model_reset();
        m_cyc   = 0;
        m_valid = 0;
        m_rise  = 0;
        m_ch    = 0;
        m_rr    = 0;
        for (int c = 0; c < N; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0;
            m_pend[c] = 0; m_dir[c] = 0; m_cnt[c] = 0;
        end
    endtask

    // One clock of the specified behaviour, using inputs present at the edge.
    task automatic model_step();
        bit old_pend [N];
        int sc, set_c, clr_c, best;
        if (rst) begin
            model_reset();
            return;
        end
        old_pend = m_pend;
        set_c = -1;
        clr_c = -1;
        // event port
        if (m_valid) begin
            if (ready) begin
                clr_c   = m_ch;
                m_rr    = (m_ch + 1) % N;
                m_valid = 0;
            end
        end else begin
            best = -1;
            for (int c = 0; c < N; c++) begin
                if (old_pend[c] && (best < 0 || ((c - m_rr + N) % N) < ((best - m_rr + N) % N)))
                    best = c;
            end
            if (best >= 0) begin
                m_valid = 1;
                m_ch    = best;
                m_rise  = REL_EN ? m_dir[best] : 1'b1;
            end
        end
        // a tick ends every T-th cycle; channel k is visited k+1 cycles later
        sc = (m_cyc >= T && (m_cyc % T) < N) ? (m_cyc % T) : -1;
        if (sc >= 0) begin
            if (m_s2[sc] == m_lvl[sc]) begin
                m_cnt[sc] = 0;
            end else if (m_cnt[sc] < SC - 1) begin
                m_cnt[sc]++;
            end else if (old_pend[sc] && (REL_EN || m_s2[sc])) begin
                m_cnt[sc] = SC - 1;
            end else begin
                m_lvl[sc] = m_s2[sc];
                m_cnt[sc] = 0;
                if (REL_EN || m_s2[sc]) begin
                    set_c      = sc;
                    m_dir[sc]  = m_s2[sc];
                end
            end
        end
        if (set_c >= 0) m_pend[set_c] = 1;
        if (clr_c >= 0) m_pend[clr_c] = 0;
        for (int c = 0; c < N; c++) begin
            m_s2[c] = m_s1[c];
            m_s1[c] = d_in[c];
        end
        m_cyc++;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic check_model();
        logic [7:0] a, e;
        logic [N-1:0] ml;
        for (int c = 0; c < N; c++) ml[c] = m_lvl[c];
        a = {o_level, o_valid, (o_valid ? o_ch : 2'b00), (o_valid ? o_rise : 1'b0)};
        e = {ml, m_valid, (m_valid ? 2'(m_ch) : 2'b00), (m_valid ? m_rise : 1'b0)};
        chk("model", 32'(a), 32'(e));
    endtask

    task automatic step();
        ev_t ev;
        if (!rst && o_valid && ready) begin
            ev.ch   = int'(o_ch);
            ev.rise = o_rise;
            ev_log.push_back(ev);
        end
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!o_valid && k < budget) begin
            step();
            k++;
        end
        chk("wait_valid", 32'(o_valid), 32'd1);
    endtask

    task automatic wait_lvl(input int ch, input logic v, input int budget);
        int k = 0;
        while (o_level[ch] !== v && k < budget) begin
            step();
            k++;
        end
        chk("wait_level", 32'(o_level[ch]), 32'(v));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        model_reset();
        #2;
        chk("reset_outs", 32'({o_level, o_valid, o_ch, o_rise}), 32'd0);
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    function automatic int log_ch(input int i);
        return (i < ev_log.size()) ? ev_log[i].ch : -1;
    endfunction

    function automatic int log_rise(input int i);
        return (i < ev_log.size()) ? int'(ev_log[i].rise) : -1;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int base;
        int stable;
        int exp_ch[$];
        int rmode;
        int bitn;

        #1;
        do_reset(3);

        // Settle-step table (ready held high, each step long enough to settle)
        vecs[0] = '{4'b0001, 1'b1, 50, 4'b0001, 1, 0};
        vecs[1] = '{4'b0011, 1'b1, 50, 4'b0011, 1, 0};
        vecs[2] = '{4'b1111, 1'b1, 50, 4'b1111, 2, 0};
        vecs[3] = '{4'b0101, 1'b1, 50, 4'b0101, 0, 2};
        vecs[4] = '{4'b1010, 1'b1, 50, 4'b1010, 2, 2};
        vecs[5] = '{4'b0000, 1'b1, 50, 4'b0000, 0, 2};
        for (int i = 0; i < 6; i++) begin
            base  = ev_log.size();
            d_in  = vecs[i].d;
            ready = vecs[i].rdy;
            repeat (vecs[i].hold) step();
            chk($sformatf("vec%0d_level", i), 32'(o_level), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d_events", i), 32'(ev_log.size() - base),
                32'(vecs[i].n_rise + (REL_EN ? vecs[i].n_fall : 0)));
        end

        // Clean press on ch1, ready high
        ready = 1'b1;
        d_in  = 4'b0010;
        wait_valid(60);
        chk("p2_ch", 32'(o_ch), 32'd1);
        chk("p2_rise", 32'(o_rise), 32'd1);
        chk("p2_level", 32'(o_level[1]), 32'd1);
        step();
        chk("p2_bubble", 32'(o_valid), 32'd0);
        chk("p2_logged", 32'(log_ch(ev_log.size() - 1)), 32'd1);

        // Two-tick glitch on ch2 must not flip
        base = ev_log.size();
        d_in = 4'b0110;
        repeat (16) step();
        d_in = 4'b0010;
        repeat (40) step();
        chk("p3_level", 32'(o_level), 32'b0010);
        chk("p3_no_event", 32'(ev_log.size() - base), 32'd0);

        // ch0 and ch3 in the same scan, consumer stalled
        base  = ev_log.size();
        ready = 1'b0;
        d_in  = 4'b1011;
        wait_valid(60);
        chk("p4_first_ch", 32'(o_ch), 32'd0);
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_valid && o_ch == 2'd0) stable++;
        end
        chk("p4_hold20", 32'(stable), 32'd20);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("p4_bubble", 32'(o_valid), 32'd0);
        step();
        chk("p4_second", 32'({o_valid, o_ch}), 32'({1'b1, 2'd3}));
        d_in = 4'b1010;
        wait_lvl(0, 1'b0, 60);
        d_in = 4'b1011;
        repeat (50) step();
        chk("p4_ch3_held", 32'({o_valid, o_ch}), 32'({1'b1, 2'd3}));
        ready = 1'b1;
        repeat (50) step();
        if (REL_EN) exp_ch = '{0, 3, 0, 0};
        else        exp_ch = '{0, 3, 0};
        chk("p4_count", 32'(ev_log.size() - base), 32'(exp_ch.size()));
        for (int i = 0; i < exp_ch.size(); i++)
            chk($sformatf("p4_order%0d", i), 32'(log_ch(base + i)), 32'(exp_ch[i]));

        // Press pending on ch1, then release while it is still pending
        d_in = 4'b1001;
        repeat (50) step();
        ready = 1'b0;
        d_in  = 4'b1011;
        wait_valid(60);
        chk("p5_pending", 32'({o_ch, o_rise}), 32'({2'd1, 1'b1}));
        base = ev_log.size();
        d_in = 4'b1001;
        repeat (40) step();
        chk("p5_level_held", 32'(o_level[1]), REL_EN ? 32'd1 : 32'd0);
        ready = 1'b1;
        repeat (50) step();
        chk("p5_count", 32'(ev_log.size() - base), REL_EN ? 32'd2 : 32'd1);
        chk("p5_ev0", 32'({log_ch(base) == 1, log_rise(base) == 1}), 32'b11);
        if (REL_EN)
            chk("p5_ev1", 32'({log_ch(base + 1) == 1, log_rise(base + 1) == 0}), 32'b11);
        chk("p5_level", 32'(o_level), 32'b1001);

        // All four pressed in one scan, ready toggling
        d_in = 4'b0000;
        repeat (50) step();
        base = ev_log.size();
        d_in = 4'b1111;
        for (int i = 0; i < 60; i++) begin
            ready = ~ready;
            step();
        end
        ready = 1'b1;
        repeat (10) step();
        chk("p6_count", 32'(ev_log.size() - base), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("p6_ev%0d", i), 32'({log_ch(base + i), log_rise(base + i)}),
                32'({i, 1}));

        // Reset with an event presented, then first-tick timing
        d_in = 4'b0000;
        repeat (50) step();
        ready = 1'b0;
        d_in  = 4'b0001;
        wait_valid(60);
        repeat (3) step();
        do_reset(3);
        repeat (24) step();
        chk("p1_level_c24", 32'(o_level[0]), 32'd0);
        step();
        chk("p1_level_c25", 32'(o_level[0]), 32'd1);
        step();
        chk("p1_valid", 32'({o_valid, o_ch}), 32'({1'b1, 2'd0}));

        // Randomized run against the model
        rmode = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 100 == 0) rmode = int'($urandom_range(0, 2));
            ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                bitn = int'($urandom_range(0, N - 1));
                d_in[bitn] = ~d_in[bitn];
            end
            if (i == 2000) do_reset(2);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
